conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
- Streaming 3x3 "same" convolution engine for the U-Net datapath; next generation of convolutor3x3.
- Generates zero padding internally, so the caller drives no left/right padding strobes. Two line buffers are sized for MAX_WIDTH; frame width and height are set at run time.
- Valid/ready handshakes on input and output; accumulator has bias, ReLU, rounding shift and saturation to OUT_W.
- Sits between the activation buffer and the next layer buffer.

Parameters:
- DATA_W, 8, signed input pixel width
- WEIGHT_W, 8, signed weight width
- ACC_W, 32, signed accumulator/bias width
- OUT_W, 8, signed output pixel width after quantisation
- MAX_WIDTH, 128, maximum frame width; sets line-buffer depth

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  frame start pulse; sampled only in IDLE
- width  in  8  frame width; legal range 2..MAX_WIDTH
- height  in  8  frame height; legal range 1..255
- weights  in  9*WEIGHT_W  slice [WEIGHT_W*(3i+j) +: WEIGHT_W] multiplies x[r-1+i][c-1+j], i,j in 0..2
- bias  in  ACC_W  signed bias
- shift  in  5  arithmetic right shift, 0..ACC_W-1
- relu  in  1  clamp negative sums to 0
- in_valid  in  1  pixel_in valid
- in_ready  out  1  block accepts pixel
- pixel_in  in  DATA_W  raster-order input pixel
- out_valid  out  1  pixel_out valid
- out_ready  in  1  downstream accepts
- pixel_out  out  OUT_W  quantised result
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after final output is accepted
- cfg_err  out  1  one-cycle pulse when start is given with an illegal width or height

Behaviour:
- Reset (async, rst=1): state IDLE, all counters zero; in_ready, out_valid, busy, done, cfg_err are 0; pixel_out is 0. Line-buffer contents are don't-care. Any in-flight frame is aborted and no partial output is emitted.
- Config capture: in IDLE, start=1 with a legal width/height latches width, height, weights, bias, shift and relu, then moves to RUN.
  - Config inputs are ignored after capture.
  - start with an illegal width or height pulses cfg_err and the block stays in IDLE.
  - start while busy is ignored.
- States:
  - IDLE: no frame active.
  - RUN: consumes H*W real pixels.
  - FLUSH: injects W+1 virtual zero pixels internally; in_ready=0 throughout.
  - DRAIN: waits for the final output to be accepted, then pulses done and returns to IDLE.
- busy=1 in every state except IDLE.
- Position counter k counts consumed positions, real or virtual: 0 .. H*W+W.
  - A real position is consumed when in_valid && in_ready.
  - A virtual position is consumed in FLUSH whenever the pipeline is not stalled.
- Output rule: the output for raster index m = r*W+c is computed when position m+W+1 is consumed. It is registered into pixel_out with out_valid=1 on the next rising edge. Outputs are emitted in raster order, exactly H*W per frame.
- Padding: taps with row <0, row ≥H, col <0 or col ≥W contribute 0. There is no leakage across row ends; the column counter masks taps at c=0 and c=W-1.
- Stall: in_ready = (state==RUN) && (!out_valid || out_ready). FLUSH advances under the same condition.
- While out_valid && !out_ready, pixel_out and out_valid stay stable.
- Arithmetic:
  - sum = Σ weight*pixel + bias, full signed, held in ACC_W.
  - If relu, negative sums become 0.
  - If shift>0, add 1<<(shift-1) and then arithmetic-shift right by shift (round half up). If shift=0, pass unchanged.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Throughput: 1 pixel/cycle with no backpressure.
- Latency: out_valid rises 1 cycle after consumption of position m+W+1.
- done: pulses the cycle after the H*W-th output handshake; busy falls on the same cycle.

Test Plan:
- Identity: center weight 1, all others 0, bias 0, shift 0, relu 0; 4x4 image 1..16 -> pixel_out 1..16 in order; done pulses once after the 16th accept; busy then 0.
- Padding: all weights 1, 3x3 image of all 1s, bias -5, relu 1 -> outputs 0,1,0,1,4,1,0,1,0.
- Quantisation, shift 4:
  - center weight 127, pixel 127, relu 0 -> 16129 rounds to 1008, saturates to 127.
  - center weight -128, pixel 127, relu 0 -> -1016, saturates to -128.
  - center weight -128, pixel 127, relu 1 -> 0.
- Backpressure: identity 4x4 test with in_valid and out_ready each randomly low 30% of cycles -> same 1..16 sequence; pixel_out stable while stalled; no pixel accepted while in_ready=0.
- Row wrap: width 5, height 2, only the x[r][c-1] tap =1, pixels 1..10 -> outputs 0,1,2,3,4,0,6,7,8,9.
- Error/reset:
  - start with width=1 -> cfg_err pulse, busy stays 0.
  - assert rst mid-frame -> all outputs 0 immediately; a new 4x4 identity frame afterwards produces correct 1..16.

Source files
------------

// File: rtl/conv3x3_stream_if.sv
// conv3x3_stream_if: pixel-in / pixel-out valid-ready stream pair for the 3x3 convolver
interface conv3x3_stream_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] pixel_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  pixel_out;

    modport master (output in_valid, pixel_in, out_ready, input in_ready, out_valid, pixel_out);
    modport slave  (input in_valid, pixel_in, out_ready, output in_ready, out_valid, pixel_out);
endinterface

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 same-padded convolution with bias, ReLU, rounding shift and saturation
module conv3x3_stream #(
    parameter int DATA_W    = 8,
    parameter int WEIGHT_W  = 8,
    parameter int ACC_W     = 32,
    parameter int OUT_W     = 8,
    parameter int MAX_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              width,
    input  logic [7:0]              height,
    input  logic [9*WEIGHT_W-1:0]   weights,
    input  logic signed [ACC_W-1:0] bias,
    input  logic [4:0]              shift,
    input  logic                    relu,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    conv3x3_stream_if.slave         bus
);
    localparam int AW = $clog2(MAX_WIDTH);
    localparam logic signed [OUT_W-1:0] QMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] QMIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

    state_t                       state;
    logic [7:0]                   w_r, h_r;
    logic [9*WEIGHT_W-1:0]        wt_r;
    logic signed [ACC_W-1:0]      bias_r;
    logic [4:0]                   shift_r;
    logic                         relu_r;
    logic [7:0]                   col;
    logic [8:0]                   row;
    logic [AW-1:0]                ci;
    logic signed [DATA_W-1:0]     lb_a [MAX_WIDTH];
    logic signed [DATA_W-1:0]     lb_b [MAX_WIDTH];
    logic signed [DATA_W-1:0]     wa [3];
    logic signed [DATA_W-1:0]     wb [3];
    logic signed [DATA_W-1:0]     px;
    logic signed [DATA_W-1:0]     tap [9];
    logic signed [DATA_W+WEIGHT_W-1:0] prod;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W:0]        rs, rnd, sh;
    logic signed [OUT_W-1:0]      q;
    logic adv, take, emit, top, bot, lft, rgt, legal, last_col;

    // Position (row, col) is the next window column to be pushed; the window center lags it by W+1.
    assign ci           = col[AW-1:0];
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = state == RUN && adv;
    assign take         = (state == RUN && bus.in_valid && adv) || (state == FLUSH && adv);
    assign px           = state == RUN ? bus.pixel_in : '0;
    assign busy         = state != IDLE;
    assign legal        = width >= 8'd2 && 32'(width) <= MAX_WIDTH && height != 8'd0;
    assign last_col     = col == w_r - 8'd1;
    assign emit         = row != 9'd0 && !(row == 9'd1 && col == 8'd0);
    assign top          = row == 9'd1 || (row == 9'd2 && col == 8'd0);
    assign bot          = row == 9'(h_r) + (col == 8'd0 ? 9'd1 : 9'd0);
    assign lft          = col == 8'd1;
    assign rgt          = col == 8'd0;

    // Assemble the 3x3 window (two stored columns plus the incoming one) and zero out-of-frame taps.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tap[3*i]   = wa[i];
            tap[3*i+1] = wb[i];
        end
        tap[2] = lb_b[ci];
        tap[5] = lb_a[ci];
        tap[8] = px;
        for (int t = 0; t < 9; t++)
            if ((t < 3 && top) || (t > 5 && bot) || (t % 3 == 0 && lft) || (t % 3 == 2 && rgt))
                tap[t] = '0;
    end

    // Multiply-accumulate, then ReLU, round-half-up shift and saturation to the output width.
    always_comb begin
        acc  = bias_r;
        prod = '0;
        for (int t = 0; t < 9; t++) begin
            prod = tap[t] * $signed(wt_r[WEIGHT_W*t +: WEIGHT_W]);
            acc  = acc + ACC_W'(prod);
        end
        rs  = relu_r && acc < 0 ? '0 : (ACC_W+1)'(acc);
        rnd = shift_r == 5'd0 ? '0 : (ACC_W+1)'(1) << (shift_r - 5'd1);
        sh  = (rs + rnd) >>> shift_r;
        q   = sh > (ACC_W+1)'(QMAX) ? QMAX : sh < (ACC_W+1)'(QMIN) ? QMIN : sh[OUT_W-1:0];
    end

    // Line buffers and window columns shift on every consumed position; contents need no reset.
    always_ff @(posedge clk) begin
        if (take) begin
            lb_a[ci] <= px;
            lb_b[ci] <= lb_a[ci];
            for (int i = 0; i < 3; i++) wa[i] <= wb[i];
            wb[0] <= lb_b[ci];
            wb[1] <= lb_a[ci];
            wb[2] <= px;
        end
    end

    // Frame control: config capture, position counters, output register and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            w_r           <= '0;
            h_r           <= '0;
            wt_r          <= '0;
            bias_r        <= '0;
            shift_r       <= '0;
            relu_r        <= 1'b0;
            col           <= '0;
            row           <= '0;
            bus.out_valid <= 1'b0;
            bus.pixel_out <= '0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (take) begin
                col <= last_col ? 8'd0 : col + 8'd1;
                row <= last_col ? row + 9'd1 : row;
            end
            if (take && emit) begin
                bus.out_valid <= 1'b1;
                bus.pixel_out <= q;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start && legal) begin
                        w_r     <= width;
                        h_r     <= height;
                        wt_r    <= weights;
                        bias_r  <= bias;
                        shift_r <= shift;
                        relu_r  <= relu;
                        col     <= '0;
                        row     <= '0;
                        state   <= RUN;
                    end else if (start) begin
                        cfg_err <= 1'b1;
                    end
                end
                RUN:   if (take && last_col && row == 9'(h_r) - 9'd1) state <= FLUSH;
                FLUSH: if (take && row == 9'(h_r) + 9'd1) state <= DRAIN;
                DRAIN: begin
                    if (bus.out_valid && bus.out_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: scoreboard bench comparing the convolver against a direct 3x3 reference
module tb_conv3x3_stream;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         width = '0;
    logic [7:0]         height = '0;
    logic [71:0]        weights = '0;
    logic signed [31:0] bias = '0;
    logic [4:0]         shift = '0;
    logic               relu = 1'b0;
    logic               busy, done, cfg_err;

    conv3x3_stream_if #(.DATA_W(8), .OUT_W(8)) bus();

    conv3x3_stream #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(32), .OUT_W(8), .MAX_WIDTH(128)) dut (
        .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
        .weights(weights), .bias(bias), .shift(shift), .relu(relu),
        .busy(busy), .done(done), .cfg_err(cfg_err), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int img[$];
    int wt[9];
    int cw, ch, cb, cs, cr;
    bit bp = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Direct same-padded 3x3 convolution followed by the quantisation rules.
    function automatic int ref_px(input int r, input int c);
        longint s;
        int y, x;
        s = cb;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                y = r - 1 + i;
                x = c - 1 + j;
                if (y >= 0 && y < ch && x >= 0 && x < cw) s += longint'(wt[3*i+j]) * img[y*cw+x];
            end
        if (cr != 0 && s < 0) s = 0;
        if (cs > 0) s = (s + (longint'(1) << (cs - 1))) >>> cs;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return int'(s);
    endfunction

    task automatic set_cfg(input int w, input int h, input int b, input int s, input int r);
        cw = w; ch = h; cb = b; cs = s; cr = r;
        for (int t = 0; t < 9; t++) wt[t] = 0;
        img.delete();
    endtask

    task automatic start_frame();
        for (int r = 0; r < ch; r++)
            for (int c = 0; c < cw; c++) exp_q.push_back(ref_px(r, c));
        @(negedge clk);
        width  = 8'(cw);
        height = 8'(ch);
        for (int t = 0; t < 9; t++) weights[8*t +: 8] = 8'(wt[t]);
        bias  = cb;
        shift = 5'(cs);
        relu  = cr != 0;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        weights = {$urandom, $urandom, $urandom};
        bias    = $urandom;
        shift   = 5'($urandom);
        relu    = 1'($urandom);
        width   = 8'($urandom);
        height  = 8'($urandom);
        #1 chk("busy_after_start", busy, 1);
    endtask

    task automatic feed(input int n);
        int idx, guard;
        idx = 0;
        guard = 0;
        while (idx < n && guard < 20000) begin
            @(negedge clk);
            bus.in_valid = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
            bus.pixel_in = 8'(img[idx]);
            #1;
            if (bus.in_valid && bus.in_ready) idx++;
            guard++;
        end
        chk("pixels_accepted", idx, n);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_frame();
        int g;
        bit got;
        g = 0;
        got = 1'b0;
        while (!got && g < 5000) begin
            @(negedge clk);
            #1 got = done;
            g++;
        end
        chk("done_seen", got, 1);
        chk("busy_at_done", busy, 0);
        chk("outputs_remaining", exp_q.size(), 0);
        @(negedge clk);
        #1 chk("done_one_cycle", done, 0);
        exp_q.delete();
    endtask

    task automatic run_frame();
        start_frame();
        feed(cw * ch);
        finish_frame();
    endtask

    task automatic bad_start(input int w, input int h);
        @(negedge clk);
        width  = 8'(w);
        height = 8'(h);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("busy_after_bad_start", busy, 0);
        @(negedge clk);
        #1;
        chk("cfg_err_cleared", cfg_err, 0);
        chk("still_idle", busy, 0);
    endtask

    task automatic identity4();
        set_cfg(4, 4, 0, 0, 0);
        wt[4] = 1;
        for (int i = 1; i <= 16; i++) img.push_back(i);
        run_frame();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_pixel_out"}, bus.pixel_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // Monitor: decides out_ready each cycle, checks stall stability and pops the scoreboard on handshakes.
    initial begin
        bit held;
        int hpx, e;
        held = 1'b0;
        hpx = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.out_ready = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
            #1;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_valid", bus.out_valid, 1);
                    chk("stall_data", bus.pixel_out, hpx);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_output: got pixel %0d, expected none", bus.pixel_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pixel", bus.pixel_out, e);
                    end
                end
                held = bus.out_valid && !bus.out_ready;
                hpx  = bus.pixel_out;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.pixel_in = '0;
        repeat (3) @(negedge clk);
        #1 check_quiet("reset");
        rst = 1'b0;

        identity4();

        set_cfg(3, 3, -5, 0, 1);
        for (int t = 0; t < 9; t++) wt[t] = 1;
        for (int i = 0; i < 9; i++) img.push_back(1);
        run_frame();

        set_cfg(2, 1, 0, 4, 0);
        wt[4] = 127;
        img = '{127, 127};
        run_frame();
        set_cfg(2, 1, 0, 4, 0);
        wt[4] = -128;
        img = '{127, 127};
        run_frame();
        set_cfg(2, 1, 0, 4, 1);
        wt[4] = -128;
        img = '{127, 127};
        run_frame();

        bp = 1'b1;
        identity4();

        bp = 1'b0;
        set_cfg(5, 2, 0, 0, 0);
        wt[3] = 1;
        for (int i = 1; i <= 10; i++) img.push_back(i);
        run_frame();

        for (int f = 0; f < 8; f++) begin
            bp = 1'($urandom);
            set_cfg($urandom_range(2, 12), $urandom_range(1, 8), int'($urandom_range(0, 40000)) - 20000,
                    $urandom_range(0, 10), $urandom_range(0, 1));
            for (int t = 0; t < 9; t++) wt[t] = int'($urandom_range(0, 255)) - 128;
            for (int i = 0; i < cw * ch; i++) img.push_back(int'($urandom_range(0, 255)) - 128);
            run_frame();
        end

        bp = 1'b0;
        set_cfg(128, 3, 100, 6, 0);
        for (int t = 0; t < 9; t++) wt[t] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < cw * ch; i++) img.push_back(int'($urandom_range(0, 255)) - 128);
        run_frame();

        bad_start(1, 4);
        bad_start(4, 0);
        bad_start(129, 4);

        bp = 1'b1;
        set_cfg(6, 6, 0, 0, 0);
        wt[4] = 1;
        for (int i = 0; i < 36; i++) img.push_back(int'($urandom_range(1, 100)));
        start_frame();
        feed(20);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_quiet("mid_reset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bp = 1'b0;
        identity4();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
